// File: rtl/sensor_packet_framer_if.sv
// Sample-in / UART-out handshake bundle for sensor_packet_framer.
// master: the framer side; slave: the ADC stage and uart_tx side.
interface sensor_packet_framer_if;
    logic       s_valid;
    logic [7:0] s_data;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;

    modport master (
        input  s_valid,
        input  s_data,
        input  tx_busy,
        output tx_start,
        output tx_data
    );

    modport slave (
        output s_valid,
        output s_data,
        output tx_busy,
        input  tx_start,
        input  tx_data
    );
endinterface

// File: rtl/sensor_packet_framer.sv
// Sample FIFO plus packet framer feeding uart_tx: SYNC, SEQ, payload samples, CHK.
// Define FRAMER_CRC8_EN to make CHK a CRC-8 (poly 0x07) instead of an 8-bit sum.
module sensor_packet_framer #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned PAYLOAD_LEN = 4,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ena,
    sensor_packet_framer_if.master       bus,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
    output logic [7:0]                   drop_cnt
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(PAYLOAD_LEN + 4);

    localparam logic [IDX_W-1:0] IDX_SEQ = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_CHK = IDX_W'(PAYLOAD_LEN + 2);
    localparam logic [IDX_W-1:0] IDX_END = IDX_W'(PAYLOAD_LEN + 3);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_PKT  = LVL_W'(PAYLOAD_LEN);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_SEND  = 3'd2;
    localparam logic [2:0] ST_GUARD = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q, level_d;
    logic [7:0]       drop_q, drop_d;
    logic [2:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       seq_q, seq_d;
    logic [7:0]       chk_q, chk_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [7:0]       load_byte;
    logic             wr_req, full, in_payload, pop, push, drop;

    function automatic logic [7:0] chk_next(input logic [7:0] chk, input logic [7:0] data);
`ifdef FRAMER_CRC8_EN
        logic [7:0] c;
        c = chk ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
`else
        return chk + data;
`endif
    endfunction

    assign wr_req     = bus.s_valid && ena;
    assign full       = (level_q == LVL_FULL);
    assign in_payload = (idx_q > IDX_SEQ) && (idx_q < IDX_CHK);
    assign pop        = (state_q == ST_LOAD) && in_payload;
    // A pop in the same cycle frees the slot, so a write to a full FIFO is still taken.
    assign push       = wr_req && (!full || pop);
    assign drop       = wr_req && full && !pop;

    always_comb begin
        if (idx_q == '0) begin
            load_byte = SYNC_BYTE;
        end else if (idx_q == IDX_SEQ) begin
            load_byte = seq_q;
        end else if (in_payload) begin
            load_byte = mem[rd_ptr_q];
        end else begin
            load_byte = chk_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        seq_d     = seq_q;
        chk_d     = chk_q;
        tx_data_d = tx_data_q;
        level_d   = level_q + LVL_W'(push) - LVL_W'(pop);
        drop_d    = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
        case (state_q)
            ST_IDLE: begin
                if (ena && level_q >= LVL_PKT && !bus.tx_busy) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
                end
            end
            ST_LOAD: begin
                tx_data_d = load_byte;
                idx_d     = idx_q + 1'b1;
                state_d   = ST_SEND;
                if (idx_q == '0) begin
                    chk_d = 8'h00;
                end else if (idx_q != IDX_CHK) begin
                    chk_d = chk_next(chk_q, load_byte);
                end
            end
            ST_SEND:  state_d = ST_GUARD;
            // uart_tx busy is registered, so it is not trustworthy until a cycle later.
            ST_GUARD: state_d = ST_WAIT;
            ST_WAIT: begin
                if (!bus.tx_busy) begin
                    if (idx_q == IDX_END) begin
                        state_d = ST_IDLE;
                        seq_d   = seq_q + 8'd1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            drop_q    <= 8'h00;
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            seq_q     <= 8'h00;
            chk_q     <= 8'h00;
            tx_data_q <= 8'h00;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q   <= level_d;
            drop_q    <= drop_d;
            state_q   <= state_d;
            idx_q     <= idx_d;
            seq_q     <= seq_d;
            chk_q     <= chk_d;
            tx_data_q <= tx_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= bus.s_data;
    end

    assign bus.tx_start = (state_q == ST_SEND);
    assign bus.tx_data  = tx_data_q;
    assign fifo_level   = level_q;
    assign drop_cnt     = drop_q;
endmodule

// File: tb/tb_sensor_packet_framer.sv
// Bench for sensor_packet_framer: directed steps plus random traffic checked against a
// packet-level model (sample queue -> expected byte stream). Honours FRAMER_CRC8_EN.
module tb_sensor_packet_framer;
    localparam int DEPTH = 8;
    localparam int P     = 4;
    localparam int PKT   = P + 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic [3:0] fifo_level;
    logic [7:0] drop_cnt;

    sensor_packet_framer_if sif();

    sensor_packet_framer #(
        .DEPTH      (DEPTH),
        .PAYLOAD_LEN(P),
        .SYNC_BYTE  (8'hA5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .bus       (sif),
        .fifo_level(fifo_level),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] ref_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] log_q[$];
    logic [7:0] seq_log[$];
    logic [7:0] pkt_body[$];
    logic [7:0] seq_m = 8'h00;
    logic [7:0] exp_b;
    int         drop_m = 0;
    int         pkt_pos = 0;
    int         pkts_done = 0;
    int         n_start = 0;
    int         busy_cnt = 0;
    int         busy_len = 10;
    bit         hold_busy = 1'b0;

    function automatic logic [7:0] ref_chk(input logic [7:0] body[$]);
        logic [7:0] acc;
`ifdef FRAMER_CRC8_EN
        logic fb;
        acc = 8'h00;
        foreach (body[i]) begin
            for (int b = 7; b >= 0; b--) begin
                fb  = acc[7] ^ body[i][b];
                acc = {acc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
`else
        acc = 8'h00;
        foreach (body[i]) acc = acc + body[i];
`endif
        return acc;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // uart_tx stand-in: busy from the cycle after tx_start for busy_len cycles; also the monitor.
    always @(posedge clk) begin
        #1;
        sif.tx_busy = hold_busy || (busy_cnt > 0);
        if (busy_cnt > 0) busy_cnt--;
        if (rst_n && sif.tx_start === 1'b1) begin
            n_start++;
            if (pkt_pos == 0) begin
                check("fifo_underflow", 32'(ref_q.size() >= P), 32'd1);
                pkt_body = {seq_m};
                for (int i = 0; i < P; i++) begin
                    pkt_body.push_back(ref_q.size() > 0 ? ref_q.pop_front() : 8'h00);
                end
                exp_q.push_back(8'hA5);
                foreach (pkt_body[i]) exp_q.push_back(pkt_body[i]);
                exp_q.push_back(ref_chk(pkt_body));
            end
            exp_b = exp_q.pop_front();
            check("tx_byte", sif.tx_data, exp_b);
            log_q.push_back(sif.tx_data);
            if (pkt_pos == 1) seq_log.push_back(sif.tx_data);
            pkt_pos++;
            if (pkt_pos == PKT) begin
                pkt_pos = 0;
                pkts_done++;
                seq_m = seq_m + 8'd1;
            end
            busy_cnt = busy_len;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic write(input logic [7:0] d);
        @(negedge clk);
        sif.s_valid = 1'b1;
        sif.s_data  = d;
        if (ena) begin
            if (ref_q.size() < DEPTH) ref_q.push_back(d);
            else if (drop_m < 255) drop_m++;
        end
        @(negedge clk);
        sif.s_valid = 1'b0;
    endtask

    task automatic wait_packets(input int target, input int budget);
        int c = 0;
        while (pkts_done < target && c < budget) begin
            tick();
            c++;
        end
        check("packet_timeout", pkts_done, target);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        ref_q.delete();
        exp_q.delete();
        pkt_pos   = 0;
        seq_m     = 8'h00;
        drop_m    = 0;
        busy_cnt  = 0;
        hold_busy = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick();
    endtask

    logic [7:0] exp1[PKT];
    int         n0, c, target;

    initial begin
        sif.s_valid = 1'b0;
        sif.s_data  = 8'h00;
        sif.tx_busy = 1'b0;
`ifdef FRAMER_CRC8_EN
        exp1 = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hE3};
`else
        exp1 = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
`endif
        tick(3);
        check("rst_tx_start", sif.tx_start, 1'b0);
        check("rst_tx_data", sif.tx_data, 8'h00);
        check("rst_fifo_level", fifo_level, 4'd0);
        check("rst_drop_cnt", drop_cnt, 8'h00);
        rst_n = 1'b1;
        ena   = 1'b1;
        tick(2);

        // Known packet, tx_busy high 10 cycles after each byte
        busy_len = 10;
        log_q.delete();
        for (int i = 1; i <= 4; i++) write(8'(i));
        wait_packets(1, 600);
        for (int i = 0; i < PKT; i++) begin
            check("t1_byte", (log_q.size() > i) ? 32'(log_q[i]) : 32'hFFFF_FFFF, exp1[i]);
        end
        tick(20);
        check("t1_level_empty", fifo_level, 4'd0);

        // ena=0: writes ignored
        ena = 1'b0;
        for (int i = 0; i < 4; i++) write(8'($urandom));
        check("ena0_no_write", fifo_level, 4'd0);
        ena = 1'b1;

        // Three samples do not start a packet; the fourth does
        busy_len = 3;
        for (int i = 0; i < 3; i++) write(8'($urandom));
        n0 = n_start;
        tick(1000);
        check("t3_no_start", n_start, n0);
        check("t3_level", fifo_level, 4'd3);
        write(8'($urandom));
        wait_packets(2, 300);

        // Packet in progress completes after ena drops
        for (int i = 0; i < 4; i++) write(8'($urandom));
        n0 = n_start;
        c  = 0;
        while (n_start == n0 && c < 100) begin
            tick();
            c++;
        end
        ena = 1'b0;
        wait_packets(3, 300);
        tick(20);
        ena = 1'b1;
        check("ena_drop_level", fifo_level, 4'd0);

        // Full FIFO with uart busy: drops, then two packets seq 00, 01
        reset_dut();
        hold_busy = 1'b1;
        for (int i = 0; i < 10; i++) write(8'($urandom));
        check("t4_level_full", fifo_level, 4'd8);
        check("t4_drop_cnt", drop_cnt, 8'd2);
        check("t4_drop_model", drop_cnt, drop_m);
        seq_log.delete();
        n0 = pkts_done;
        hold_busy = 1'b0;
        wait_packets(n0 + 2, 600);
        check("t4_seq0", (seq_log.size() > 0) ? 32'(seq_log[0]) : 32'hFFFF_FFFF, 8'h00);
        check("t4_seq1", (seq_log.size() > 1) ? 32'(seq_log[1]) : 32'hFFFF_FFFF, 8'h01);
        tick(20);
        check("t4_level_empty", fifo_level, 4'd0);

        // Random traffic until seq wraps FF -> 00
        target = pkts_done + 255;
        c = 0;
        while (pkts_done < target && c < 60000) begin
            @(negedge clk);
            busy_len = $urandom_range(0, 3);
            if (ref_q.size() < P && $urandom_range(0, 1) == 1) begin
                sif.s_valid = 1'b1;
                sif.s_data  = 8'($urandom);
                ref_q.push_back(sif.s_data);
            end else begin
                sif.s_valid = 1'b0;
            end
            c++;
        end
        @(negedge clk);
        sif.s_valid = 1'b0;
        check("t5_packets", pkts_done, target);
        check("t5_seq_wrap", (seq_log.size() > 0) ? 32'(seq_log[$]) : 32'hFFFF_FFFF, 8'h00);
        tick(30);
        check("t5_level", fifo_level, ref_q.size());
        check("t5_drop_cnt", drop_cnt, 8'd2);

        // Reset mid-packet after the third byte
        while (ref_q.size() < P) write(8'($urandom));
        busy_len = 2;
        c = 0;
        while (pkt_pos != 3 && c < 300) begin
            tick();
            c++;
        end
        check("t6_reached_byte3", pkt_pos, 3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_rst_tx_start", sif.tx_start, 1'b0);
        check("t6_rst_level", fifo_level, 4'd0);
        ref_q.delete();
        exp_q.delete();
        pkt_pos  = 0;
        seq_m    = 8'h00;
        drop_m   = 0;
        busy_cnt = 0;
        tick(2);
        rst_n = 1'b1;
        tick();
        log_q.delete();
        n0 = pkts_done;
        for (int i = 0; i < 4; i++) write(8'($urandom));
        wait_packets(n0 + 1, 300);
        check("t6_sync", (log_q.size() > 0) ? 32'(log_q[0]) : 32'hFFFF_FFFF, 8'hA5);
        check("t6_seq", (log_q.size() > 1) ? 32'(log_q[1]) : 32'hFFFF_FFFF, 8'h00);
        check("t6_drop_cleared", drop_cnt, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
